// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding uart_min: buffers pushes and issues write strobes
// spaced GAP_CYCLES clocks apart so the serializer is never overrun.
module uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int GAP_CYCLES = 4340
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                push,
    input  logic [7:0]          push_data,
    output logic                full,
    output logic                empty,
    output logic [DEPTH_LOG2:0] count,
    output logic                overflow,
    output logic                tx_write,
    output logic [7:0]          tx_data
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [15:0] GAP_LOAD = 16'(GAP_CYCLES - 3);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } state_e;

    logic [7:0]          mem_q [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr_q;
    logic [DEPTH_LOG2:0] rd_ptr_q;
    logic [DEPTH_LOG2:0] count_q;
    logic [DEPTH_LOG2:0] count_d;
    logic                full_q;
    logic                empty_q;
    logic                ovf_q;
    logic                tx_write_q;
    logic [7:0]          tx_data_q;
    logic [15:0]         gap_q;
    state_e              state_q;
    logic                push_ok;
    logic                pop;

    // Acceptance uses the registered full flag; a same-cycle pop never rescues it.
    assign push_ok = push && !full_q;
    assign pop     = (state_q == IDLE) && !empty_q;

    always_comb begin
        count_d = count_q;
        unique case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            ovf_q      <= 1'b0;
            tx_write_q <= 1'b0;
            tx_data_q  <= 8'h00;
            gap_q      <= '0;
            state_q    <= IDLE;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (push && full_q) begin
                ovf_q <= 1'b1;
            end
            count_q    <= count_d;
            full_q     <= count_d[DEPTH_LOG2];
            empty_q    <= (count_d == '0);
            tx_write_q <= 1'b0;
            // SEND(1) + GAP(GAP_CYCLES-2) + IDLE(1) = GAP_CYCLES per byte
            unique case (state_q)
                IDLE: begin
                    if (pop) begin
                        tx_data_q  <= mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
                        rd_ptr_q   <= rd_ptr_q + 1'b1;
                        tx_write_q <= 1'b1;
                        state_q    <= SEND;
                    end
                end
                SEND: begin
                    gap_q   <= GAP_LOAD;
                    state_q <= GAP;
                end
                GAP: begin
                    if (gap_q == '0) begin
                        state_q <= IDLE;
                    end else begin
                        gap_q <= gap_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign full     = full_q;
    assign empty    = empty_q;
    assign count    = count_q;
    assign overflow = ovf_q;
    assign tx_write = tx_write_q;
    assign tx_data  = tx_data_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: two instances (short and long gap) checked
// against a queue-and-timestamp reference model.
module tb_uart_tx_fifo;

    localparam int GAP_A = 8;
    localparam int GAP_B = 4340;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       pa = 1'b0, pb = 1'b0;
    logic [7:0] pda = 8'h00, pdb = 8'h00;
    logic       fa, ea, oa, wa;
    logic       fb, eb, ob, wb;
    logic [4:0] ca, cb;
    logic [7:0] da, db;

    int n_tests = 0;
    int n_fail  = 0;
    bit mon_en  = 1'b0;

    always #5 clk = ~clk;

    uart_tx_fifo #(.DEPTH_LOG2(4), .GAP_CYCLES(GAP_A)) u_a (
        .clk(clk), .clr(clr), .push(pa), .push_data(pda),
        .full(fa), .empty(ea), .count(ca), .overflow(oa),
        .tx_write(wa), .tx_data(da)
    );

    uart_tx_fifo #(.DEPTH_LOG2(4), .GAP_CYCLES(GAP_B)) u_b (
        .clk(clk), .clr(clr), .push(pb), .push_data(pdb),
        .full(fb), .empty(eb), .count(cb), .overflow(ob),
        .tx_write(wb), .tx_data(db)
    );

    // Reference: a byte list with head/tail indices and the earliest
    // cycle at which the next strobe may start.
    int       head [2];
    int       tail [2];
    int       nxt  [2];
    int       cyc  [2];
    bit [7:0] mbuf [2][64];
    bit       mw   [2];
    bit [7:0] md   [2];
    bit       mo   [2];

    always @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < 2; i++) begin
                head[i] <= 0;
                tail[i] <= 0;
                nxt[i]  <= 0;
                cyc[i]  <= 0;
                mw[i]   <= 1'b0;
                md[i]   <= 8'h00;
                mo[i]   <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                automatic int       pre = tail[i] - head[i];
                automatic bit       pop = (pre > 0) && (cyc[i] >= nxt[i]);
                automatic logic     p   = (i == 0) ? pa : pb;
                automatic bit [7:0] d   = (i == 0) ? pda : pdb;
                cyc[i] <= cyc[i] + 1;
                mw[i]  <= pop;
                if (pop) begin
                    md[i]   <= mbuf[i][head[i] % 64];
                    head[i] <= head[i] + 1;
                    nxt[i]  <= cyc[i] + ((i == 0) ? GAP_A : GAP_B);
                end
                if (p === 1'b1) begin
                    if (pre == 16) begin
                        mo[i] <= 1'b1;
                    end else begin
                        mbuf[i][tail[i] % 64] <= d;
                        tail[i] <= tail[i] + 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < 2; i++) begin
                automatic int        n   = tail[i] - head[i];
                automatic logic [16:0] got = (i == 0) ?
                    {wa, da, ca, fa, ea, oa} : {wb, db, cb, fb, eb, ob};
                automatic logic [16:0] exp = {mw[i], md[i], 5'(n),
                    n == 16, n == 0, mo[i]};
                n_tests++;
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL model_dut%0d got %h exp %h (w,data,cnt,f,e,ovf)",
                             i, got, exp);
                end
            end
        end
    end

    task automatic test_reset;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            pa  = k[0];
            pb  = ~k[0];
            pda = 8'($urandom);
            pdb = 8'($urandom);
        end
        @(negedge clk);
        pa = 1'b0;
        pb = 1'b0;
        mon_en = 1'b1;
        n_tests++;
        if ({wa, da, ca, fa, ea, oa} !== 17'b0_00000000_00000_0_1_0) begin
            n_fail++;
            $display("FAIL reset_hold got %h exp %h", {wa, da, ca, fa, ea, oa},
                     17'b0_00000000_00000_0_1_0);
        end
        #2 clr = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({wb, db, cb, fb, eb, ob} !== 17'b0_00000000_00000_0_1_0) begin
            n_fail++;
            $display("FAIL reset_release got %h exp %h", {wb, db, cb, fb, eb, ob},
                     17'b0_00000000_00000_0_1_0);
        end
    endtask

    task automatic test_single;
        pa  = 1'b1;
        pda = 8'h9B;
        @(negedge clk);
        pa = 1'b0;
        n_tests++;
        if (wa !== 1'b0 || ca !== 5'd1) begin
            n_fail++;
            $display("FAIL single_e0 got w=%b cnt=%0d exp w=0 cnt=1", wa, ca);
        end
        @(negedge clk);
        n_tests++;
        if (wa !== 1'b1 || da !== 8'h9B || ca !== 5'd0) begin
            n_fail++;
            $display("FAIL single_e1 got w=%b d=%h cnt=%0d exp w=1 d=9b cnt=0",
                     wa, da, ca);
        end
        @(negedge clk);
        n_tests++;
        if (wa !== 1'b0 || da !== 8'h9B) begin
            n_fail++;
            $display("FAIL single_e2 got w=%b d=%h exp w=0 d=9b", wa, da);
        end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_burst;
        for (int k = 0; k < 40; k++) begin
            automatic bit exp_w = (k % 8 == 1) && (k <= 33);
            pa  = (k < 5);
            pda = 8'(k + 1);
            @(negedge clk);
            n_tests++;
            if (wa !== exp_w || (exp_w && da !== 8'(k / 8 + 1))) begin
                n_fail++;
                $display("FAIL burst_e%0d got w=%b d=%h exp w=%b d=%h",
                         k, wa, da, exp_w, 8'(k / 8 + 1));
            end
            if (k == 33) begin
                n_tests++;
                if (ea !== 1'b1) begin
                    n_fail++;
                    $display("FAIL burst_empty got %b exp 1", ea);
                end
            end
        end
        pa = 1'b0;
    endtask

    task automatic test_overflow;
        logic [7:0] first = 8'h00;
        int strobes = 0;
        for (int k = 0; k < 20; k++) begin
            pb  = 1'b1;
            pdb = 8'($urandom);
            if (k == 0) first = pdb;
            @(negedge clk);
            n_tests++;
            if (fb !== (k >= 16) || ob !== (k >= 17)) begin
                n_fail++;
                $display("FAIL ovf_e%0d got full=%b ovf=%b exp full=%b ovf=%b",
                         k, fb, ob, k >= 16, k >= 17);
            end
            if (k == 1) begin
                n_tests++;
                if (wb !== 1'b1 || db !== first) begin
                    n_fail++;
                    $display("FAIL ovf_first got w=%b d=%h exp w=1 d=%h",
                             wb, db, first);
                end
            end
        end
        pb = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (wb) strobes++;
        end
        n_tests++;
        if (strobes != 0 || cb !== 5'd16 || ob !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_hold got strobes=%0d cnt=%0d ovf=%b exp 0 16 1",
                     strobes, cb, ob);
        end
    endtask

    task automatic test_wrap;
        logic [7:0] sent [$];
        logic [7:0] got  [$];
        bit saw_full = 1'b0;
        for (int b = 0; b < 40; b++) begin
            automatic int idle = $urandom_range(7, 11);
            pa  = 1'b1;
            pda = 8'($urandom);
            sent.push_back(pda);
            for (int c = 0; c <= idle; c++) begin
                @(negedge clk);
                pa = 1'b0;
                if (wa) got.push_back(da);
                if (fa) saw_full = 1'b1;
            end
        end
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (wa) got.push_back(da);
            if (fa) saw_full = 1'b1;
        end
        n_tests++;
        if (got.size() != 40 || saw_full) begin
            n_fail++;
            $display("FAIL wrap_size got n=%0d full=%b exp n=40 full=0",
                     got.size(), saw_full);
        end
        for (int i = 0; i < 40 && i < got.size(); i++) begin
            n_tests++;
            if (got[i] !== sent[i]) begin
                n_fail++;
                $display("FAIL wrap_byte%0d got %h exp %h", i, got[i], sent[i]);
            end
        end
    endtask

    task automatic test_reset_gap;
        int strobes = 0;
        for (int k = 0; k < 3; k++) begin
            pa  = 1'b1;
            pda = 8'hA0 + 8'(k);
            @(negedge clk);
        end
        pa = 1'b0;
        repeat (2) @(negedge clk);
        #2 clr = 1'b0;
        #1;
        n_tests++;
        if (wa !== 1'b0 || ca !== 5'd0 || ea !== 1'b1) begin
            n_fail++;
            $display("FAIL rstgap_now got w=%b cnt=%0d e=%b exp 0 0 1", wa, ca, ea);
        end
        repeat (3) @(negedge clk);
        #2 clr = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (wa) strobes++;
        end
        n_tests++;
        if (strobes != 0 || ob !== 1'b0) begin
            n_fail++;
            $display("FAIL rstgap_stale got strobes=%0d ovf_b=%b exp 0 0",
                     strobes, ob);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_wrap();
        test_reset_gap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
